// File: rtl/prog_sequencer.sv
// prog_sequencer
// Launches three core programs in a fixed order (0 multiply, 1 pattern search,
// 2 closest pair) and collects each program's result from data memory.
// For every program the core is held in reset for HOLD_CYCLES cycles and then
// released. The sequencer waits for core_done, reads the result bytes, and
// moves on to the next program. If a program runs for TIMEOUT_CYCLES cycles
// without finishing, the sequence stops in an error state.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low
//   go         : one-cycle request to start the sequence (ignored while busy)
//   core_rst   : active-high core reset; its falling edge launches core_prog
//   core_prog  : program select (0..2)
//   core_done  : level from the core, high when the current program is finished
//   mem_rd_en  : data-memory read strobe
//   mem_addr   : data-memory read address
//   mem_rdata  : read data, valid one cycle after mem_rd_en
//   res_prod   : program 0 result {mem[4], mem[5]}
//   res_count  : program 1 result mem[7]
//   res_dist   : program 2 result mem[127]
//   res_valid  : bit n set once program n's result has been captured
//   busy       : high while a sequence is in progress
//   all_done   : high once all three results are captured
//   err        : high after a program timed out
//   err_prog   : program that timed out
module prog_sequencer #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
  parameter logic [7:0]  HOLD_CYCLES    = 8'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  output logic        core_rst,
  output logic [1:0]  core_prog,
  input  logic        core_done,
  output logic        mem_rd_en,
  output logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] res_prod,
  output logic [7:0]  res_count,
  output logic [7:0]  res_dist,
  output logic [2:0]  res_valid,
  output logic        busy,
  output logic        all_done,
  output logic        err,
  output logic [1:0]  err_prog
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    RUN  = 3'd2,
    READ = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [7:0]  hold_cnt, hold_cnt_next;
  logic [19:0] run_cnt, run_cnt_next;
  logic [1:0]  rd_idx, rd_idx_next;
  logic        core_rst_next, mem_rd_en_next, busy_next, all_done_next, err_next;
  logic [1:0]  core_prog_next, err_prog_next;
  logic [7:0]  mem_addr_next, res_count_next, res_dist_next;
  logic [15:0] res_prod_next;
  logic [2:0]  res_valid_next;
  logic        prog_finished;

  // Address of the first (or only) result byte of a program.
  function automatic logic [7:0] first_addr(input logic [1:0] prog);
    case (prog)
      2'd0:    first_addr = 8'd4;
      2'd1:    first_addr = 8'd7;
      default: first_addr = 8'd127;
    endcase
  endfunction

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_next     = state;
    hold_cnt_next  = hold_cnt;
    run_cnt_next   = run_cnt;
    rd_idx_next    = rd_idx;
    core_prog_next = core_prog;
    err_prog_next  = err_prog;
    mem_rd_en_next = 1'b0;
    mem_addr_next  = mem_addr;
    res_prod_next  = res_prod;
    res_count_next = res_count;
    res_dist_next  = res_dist;
    res_valid_next = res_valid;
    prog_finished  = 1'b0;

    case (state)
      IDLE, DONE, ERR: begin
        if (go) begin
          state_next     = HOLD;
          hold_cnt_next  = 8'd0;
          core_prog_next = 2'd0;
          err_prog_next  = 2'd0;
          res_prod_next  = 16'd0;
          res_count_next = 8'd0;
          res_dist_next  = 8'd0;
          res_valid_next = 3'd0;
        end else begin
          state_next = state;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_CYCLES - 8'd1) begin
          state_next   = RUN;
          run_cnt_next = 20'd0;
        end else begin
          hold_cnt_next = hold_cnt + 8'd1;
        end
      end
      RUN: begin
        // run_cnt == 0 marks the first RUN cycle, where a stale core_done
        // left over from before the launch must not be trusted.
        if ((run_cnt != 20'd0) && core_done) begin
          state_next     = READ;
          rd_idx_next    = 2'd0;
          mem_rd_en_next = 1'b1;
          mem_addr_next  = first_addr(core_prog);
        end else if (run_cnt == TIMEOUT_CYCLES - 20'd1) begin
          state_next    = ERR;
          err_prog_next = core_prog;
        end else begin
          run_cnt_next = run_cnt + 20'd1;
        end
      end
      READ: begin
        // rd_idx counts READ cycles; data for the strobe of cycle k is
        // captured at the end of cycle k+1.
        rd_idx_next = rd_idx + 2'd1;
        case (core_prog)
          2'd0: begin
            case (rd_idx)
              2'd0: begin
                mem_rd_en_next = 1'b1;
                mem_addr_next  = 8'd5;
              end
              2'd1: res_prod_next[15:8] = mem_rdata;
              2'd2: begin
                res_prod_next[7:0] = mem_rdata;
                res_valid_next[0]  = 1'b1;
                prog_finished      = 1'b1;
              end
              default: prog_finished = 1'b0;
            endcase
          end
          2'd1: begin
            if (rd_idx == 2'd1) begin
              res_count_next    = mem_rdata;
              res_valid_next[1] = 1'b1;
              prog_finished     = 1'b1;
            end else begin
              prog_finished = 1'b0;
            end
          end
          default: begin
            if (rd_idx == 2'd1) begin
              res_dist_next     = mem_rdata;
              res_valid_next[2] = 1'b1;
              prog_finished     = 1'b1;
            end else begin
              prog_finished = 1'b0;
            end
          end
        endcase
        if (prog_finished) begin
          if (core_prog == 2'd2) begin
            state_next = DONE;
          end else begin
            state_next     = HOLD;
            hold_cnt_next  = 8'd0;
            core_prog_next = core_prog + 2'd1;
          end
        end else begin
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase

    // The core is held in reset everywhere except while a program runs or
    // its result is being read.
    core_rst_next = (state_next != RUN) && (state_next != READ);
    busy_next     = (state_next == HOLD) || (state_next == RUN) || (state_next == READ);
    all_done_next = (state_next == DONE);
    err_next      = (state_next == ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      hold_cnt  <= 8'd0;
      run_cnt   <= 20'd0;
      rd_idx    <= 2'd0;
      core_rst  <= 1'b1;
      core_prog <= 2'd0;
      mem_rd_en <= 1'b0;
      mem_addr  <= 8'd0;
      res_prod  <= 16'd0;
      res_count <= 8'd0;
      res_dist  <= 8'd0;
      res_valid <= 3'd0;
      busy      <= 1'b0;
      all_done  <= 1'b0;
      err       <= 1'b0;
      err_prog  <= 2'd0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_cnt_next;
      run_cnt   <= run_cnt_next;
      rd_idx    <= rd_idx_next;
      core_rst  <= core_rst_next;
      core_prog <= core_prog_next;
      mem_rd_en <= mem_rd_en_next;
      mem_addr  <= mem_addr_next;
      res_prod  <= res_prod_next;
      res_count <= res_count_next;
      res_dist  <= res_dist_next;
      res_valid <= res_valid_next;
      busy      <= busy_next;
      all_done  <= all_done_next;
      err       <= err_next;
      err_prog  <= err_prog_next;
    end
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20'd100000: maximum RUN cycles allowed per program.
REQ-002 Parameter HOLD_CYCLES, default 2: number of cycles core_rst is held per program launch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; sampled only on rising clk.
REQ-005 go  input  1  single-cycle request to run programs 0,1,2 in order.
REQ-006 core_rst  output  1  active-high reset to the core; deasserting it launches the selected program.
REQ-007 core_prog  output  2  program select to the core: 0 multiply, 1 pattern search, 2 closest pair.
REQ-008 core_done  input  1  level from the core; high when the current program has finished.
REQ-009 mem_rd_en  output  1  data-memory read strobe.
REQ-010 mem_addr  output  8  data-memory read address.
REQ-011 mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 res_prod  output  16  program 0 result, {mem[4],mem[5]}.
REQ-013 res_count  output  8  program 1 result, mem[7].
REQ-014 res_dist  output  8  program 2 result, mem[127].
REQ-015 res_valid  output  3  bit n high once program n's result is captured.
REQ-016 busy  output  1  high in every state except IDLE, DONE and ERR.
REQ-017 all_done  output  1  high in DONE.
REQ-018 err  output  1  high in ERR; err_prog  output  2  program that timed out.

Function
REQ-019 The FSM SHALL have states IDLE, HOLD, RUN, READ, DONE and ERR.
REQ-020 IDLE/DONE/ERR + go SHALL move to HOLD with core_prog=0, res_valid=0 and all result outputs cleared.
REQ-021 go SHALL be ignored while busy=1.
REQ-022 HOLD SHALL assert core_rst for exactly HOLD_CYCLES cycles, then enter RUN with core_rst=0.
REQ-023 RUN SHALL ignore core_done in its first cycle; from the second cycle on, core_done=1 SHALL move the FSM to READ.
REQ-024 The RUN cycle counter SHALL clear on RUN entry; reaching TIMEOUT_CYCLES without core_done SHALL move to ERR.
REQ-025 In ERR: err=1, err_prog=core_prog, core_rst=1; earlier res_valid bits SHALL be retained.
REQ-026 READ SHALL issue mem_rd_en one cycle per address: prog 0 reads 4 then 5; prog 1 reads 7; prog 2 reads 127.
REQ-027 Each byte SHALL be captured on the cycle after its strobe; res_valid[n] SHALL set on the cycle the last byte of program n is captured.
REQ-028 After capture: if core_prog<2, increment core_prog and re-enter HOLD; if core_prog=2, go to DONE.
REQ-029 DONE SHALL hold core_rst=1 and keep results stable until the next go.
REQ-030 mem_rd_en SHALL be 0 outside READ; mem_addr is don't-care when mem_rd_en=0.
REQ-031 core_prog SHALL never take the value 3.

Reset
REQ-032 While reset=0 at a clock edge, the FSM SHALL go to IDLE with core_rst=1, core_prog=0, mem_rd_en=0, mem_addr=0, results=0, res_valid=0, busy=0, all_done=0, err=0, err_prog=0 and the counters cleared.
REQ-033 A reset in any state, including mid-READ, SHALL abort the sequence; no partial result SHALL become valid.

Verification
REQ-034 Nominal run: memory model mem[4]=8'h00, mem[5]=8'h96, mem[7]=8'd12, mem[127]=8'd3; core_done rises 50 cycles after each core_rst deassertion; one go pulse -> res_prod=16'd150, res_count=12, res_dist=3, res_valid=3'b111, all_done=1.
REQ-035 Launch timing: one go pulse -> core_rst high for exactly 2 cycles per program; core_prog steps 0,1,2; exactly 4 mem_rd_en strobes at addresses 4, 5, 7, 127.
REQ-036 Timeout: TIMEOUT_CYCLES=100, core_done never asserted for program 1 -> err=1, err_prog=1, res_valid=3'b001, core_rst=1.
REQ-037 Stale done: core_done held high through HOLD -> it is ignored in the first RUN cycle, and READ is entered on the second RUN cycle.
REQ-038 Reset in the cycle between the mem_rd_en for address 4 and the one for address 5 -> all outputs return to reset values; a following go reruns the full sequence correctly.
REQ-039 Ignored go: go pulsed during RUN of program 1 -> no restart and no result change; a go in DONE clears the results and restarts at program 0.
